seq_sorter: RTL and testbench

SEQ_SORTER -- requirements
Module: seq_sorter

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_cas.sv | 19 +
 rtl/seq_sorter.sv | 122 ++++++++++++
 tb/tb_seq_sorter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the odd-even transposition sorter.
package sort_pkg;

  // State encodings
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SORT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    SORT = ST_SORT_ENC,
    DONE = ST_DONE_ENC
  } state_e;

  // Phase parity: an even phase works on pairs (0,1),(2,3)...; an odd phase on (1,2),(3,4)...
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/sort_cas.sv
// Combinational compare-swap for one adjacent pair. The compare is strict,
// so equal elements are never swapped.
module sort_cas #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  input  logic         enable,
  output logic [W-1:0] lo_out,
  output logic [W-1:0] hi_out,
  output logic         swapped
);

  assign swapped = enable && (desc ? (a < b) : (a > b));
  assign lo_out  = swapped ? b : a;
  assign hi_out  = swapped ? a : b;

endmodule

// File: rtl/seq_sorter.sv
// Sequential odd-even transposition sorter: one phase per clock, early exit
// after two consecutive swap-free phases, hard stop after N phases.
module seq_sorter
  import sort_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   desc,
  input  logic [N*W-1:0]         data_in,
  output logic [N*W-1:0]         data_out,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(N+1)-1:0] phases
);

  localparam int PW = $clog2(N+1);

  state_e                 state_q, state_d;
  logic [N-1:0][W-1:0]    work_q, work_d, phase_res;
  logic [N-2:0][W-1:0]    lo, hi;
  logic [N-2:0]           sw, en;
  logic                   desc_q, desc_d;
  logic                   prev_sw_q, prev_sw_d;
  logic [PW-1:0]          cnt_q, cnt_d, phases_q, phases_d;
  logic [N*W-1:0]         dout_q, dout_d;
  logic                   parity, any_sw;

  // Phase parity follows the phase count, so the first phase after load is even.
  assign parity = cnt_q[0];
  assign any_sw = |sw;

  for (genvar g = 0; g < N-1; g++) begin : g_cas
    localparam logic PAR = ((g % 2) == 0) ? EVEN : ODD;
    assign en[g] = (parity == PAR);
    sort_cas #(.W(W)) u_cas (
      .a      (work_q[g]),
      .b      (work_q[g+1]),
      .desc   (desc_q),
      .enable (en[g]),
      .lo_out (lo[g]),
      .hi_out (hi[g]),
      .swapped(sw[g])
    );
  end

  // Apply only the pairs active this phase; inactive pairs overlap active ones.
  always_comb begin
    phase_res = work_q;
    for (int i = 0; i < N-1; i++) begin
      if (en[i]) begin
        phase_res[i]   = lo[i];
        phase_res[i+1] = hi[i];
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    prev_sw_d = prev_sw_q;
    desc_d    = desc_q;
    dout_d    = dout_q;
    phases_d  = phases_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d    = data_in;
          desc_d    = desc;
          cnt_d     = '0;
          // No phase precedes the first one, so it can never trigger the early exit.
          prev_sw_d = 1'b1;
          state_d   = SORT;
        end
      end
      SORT: begin
        work_d    = phase_res;
        cnt_d     = cnt_q + PW'(1);
        prev_sw_d = any_sw;
        if ((!any_sw && !prev_sw_q) || (cnt_d == PW'(N))) begin
          dout_d   = phase_res;
          phases_d = cnt_d;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and working registers, all cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      prev_sw_q <= 1'b0;
      desc_q    <= 1'b0;
      dout_q    <= '0;
      phases_q  <= '0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      prev_sw_q <= prev_sw_d;
      desc_q    <= desc_d;
      dout_q    <= dout_d;
      phases_q  <= phases_d;
    end
  end

  assign data_out = dout_q;
  assign phases   = phases_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_sorter.sv
// Bench for seq_sorter: directed N=4/W=8 jobs and randomized N=8/W=16 jobs,
// expected results queued at launch and popped when done pulses.
module tb_seq_sorter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start4, desc4, busy4, done4;
  logic [31:0]  din4, dout4;
  logic [2:0]   ph4;
  logic         start8, desc8, busy8, done8;
  logic [127:0] din8, dout8;
  logic [3:0]   ph8;

  logic [31:0]  q4[$];
  logic [127:0] q8[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           lat, ph, seen;
  logic [127:0] v;

  always #5 clk = ~clk;

  seq_sorter #(.N(4), .W(8)) u4 (
    .clk(clk), .reset_n(rst_n), .start(start4), .desc(desc4), .data_in(din4),
    .data_out(dout4), .busy(busy4), .done(done4), .phases(ph4)
  );

  seq_sorter #(.N(8), .W(16)) u8 (
    .clk(clk), .reset_n(rst_n), .start(start8), .desc(desc8), .data_in(din8),
    .data_out(dout8), .busy(busy8), .done(done8), .phases(ph8)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: insertion sort of n elements of width w.
  function automatic logic [127:0] ref_sort(input logic [127:0] x, input int n, input int w, input logic d);
    logic [31:0]  e[8];
    logic [31:0]  t;
    logic [127:0] r;
    logic [127:0] msk;
    int           j;
    msk = (128'd1 << w) - 128'd1;
    for (int i = 0; i < n; i++) e[i] = 32'((x >> (i*w)) & msk);
    for (int i = 1; i < n; i++) begin
      t = e[i];
      j = i - 1;
      while (j >= 0 && (d ? (e[j] < t) : (e[j] > t))) begin
        e[j+1] = e[j];
        j--;
      end
      e[j+1] = t;
    end
    r = '0;
    for (int i = 0; i < n; i++) r |= 128'(e[i]) << (i*w);
    return r;
  endfunction

  // One N=4 job; optionally a second start with other data is driven during SORT.
  task automatic job4(input logic [31:0] din, input logic d, input logic [31:0] exp,
                      input bit intr, input logic [31:0] idat, output int l, output int p);
    logic [31:0] prev_out;
    @(negedge clk);
    prev_out = dout4;
    din4 = din; desc4 = d; start4 = 1'b1;
    q4.push_back(exp);
    @(negedge clk);
    start4 = 1'b0;
    l = 1;
    chk("busy4", 128'(busy4), 128'(1));
    if (intr) begin
      din4 = idat; start4 = 1'b1;
      chk("out_hold_sort", 128'(dout4), 128'(prev_out));
      @(negedge clk);
      start4 = 1'b0;
      l = 2;
    end
    while (done4 !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
    if (done4 !== 1'b1) chk("timeout4", 128'(0), 128'(1));
    chk("data4", 128'(dout4), 128'(q4.pop_front()));
    chk("lat4", 128'(l), 128'(int'(ph4) + 1));
    chk("L4_range", 128'(ph4 >= 3'd2 && ph4 <= 3'd4), 128'(1));
    p = int'(ph4);
    @(negedge clk);
    chk("done_pulse4", 128'(done4), 128'(0));
  endtask

  task automatic job8(input logic [127:0] din, input logic d);
    int l;
    @(negedge clk);
    din8 = din; desc8 = d; start8 = 1'b1;
    q8.push_back(ref_sort(din, 8, 16, d));
    @(negedge clk);
    start8 = 1'b0;
    l = 1;
    while (done8 !== 1'b1 && l < 30) begin
      @(negedge clk);
      l++;
    end
    if (done8 !== 1'b1) chk("timeout8", 128'(0), 128'(1));
    chk("data8", dout8, q8.pop_front());
    chk("L8_range", 128'(ph8 >= 4'd2 && ph8 <= 4'd8 && l == int'(ph8) + 1), 128'(1));
    @(negedge clk);
    chk("done_pulse8", 128'(done8), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; desc4 = 1'b0; din4 = '0;
    start8 = 1'b0; desc8 = 1'b0; din8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy4), 128'(0));
    chk("rst_done", 128'(done4), 128'(0));
    chk("rst_dout", 128'(dout4), 128'(0));
    chk("rst_ph", 128'(ph4), 128'(0));
    chk("rst_dout8", dout8, 128'(0));
    rst_n = 1'b1;

    // 9,3,7,1 ascending
    job4({8'd1, 8'd7, 8'd3, 8'd9}, 1'b0, {8'd9, 8'd7, 8'd3, 8'd1}, 1'b0, '0, lat, ph);
    // already sorted: two swap-free phases
    job4({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, '0, lat, ph);
    chk("L_sorted", 128'(ph), 128'(2));
    chk("lat_sorted", 128'(lat), 128'(3));
    // descending with extremes and duplicates
    job4({8'd5, 8'd5, 8'd255, 8'd0}, 1'b1, {8'd0, 8'd5, 8'd5, 8'd255}, 1'b0, '0, lat, ph);
    // start while busy is ignored, then the new data sorts on the next start
    job4({8'd2, 8'd3, 8'd1, 8'd4}, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1,
         {8'd5, 8'd7, 8'd6, 8'd8}, lat, ph);
    job4({8'd5, 8'd7, 8'd6, 8'd8}, 1'b0, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, '0, lat, ph);

    // reset mid-SORT
    @(negedge clk);
    din4 = {8'd10, 8'd40, 8'd30, 8'd20}; desc4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("busy_pre_rst", 128'(busy4), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy4), 128'(0));
    chk("mid_rst_done", 128'(done4), 128'(0));
    chk("mid_rst_dout", 128'(dout4), 128'(0));
    chk("mid_rst_ph", 128'(ph4), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) seen++;
    end
    chk("rst_nodone", 128'(seen), 128'(0));
    job4({8'd25, 8'd50, 8'd100, 8'd200}, 1'b0, {8'd200, 8'd100, 8'd50, 8'd25}, 1'b0, '0, lat, ph);

    // randomized N=8, W=16 jobs
    for (int j = 0; j < 1000; j++) begin
      v = '0;
      for (int k = 0; k < 8; k++) begin
        case (j % 4)
          0:       v[k*16 +: 16] = 16'($urandom_range(0, 3));
          1:       v[k*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
          default: v[k*16 +: 16] = 16'($urandom);
        endcase
      end
      job8(v, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
